col_processor: RTL and testbench
================================

Name: col_processor

Overview:
- Column-direction stage of the 2-D wavelet transformer.
- Performs one 5/3 integer lifting step vertically on a row pair. Per column it receives three vertically adjacent pixels (even row 2k, odd row 2k+1, even row 2k+2) and produces one low-pass (s) and one high-pass (d) coefficient.
- Sits between the row bank, which supplies the three rows and the boundary mirroring, and the coefficient writer.
- A run of LENGTH columns is processed per start pulse, one column per cycle.

Parameters:
LENGTH, 256, columns per row. Also the depth of the internal previous-d bank.

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
en  input  1  start pulse; begins a pass of LENGTH columns
row_0  input  8  unsigned pixel, even row 2k, current column
row_1  input  8  unsigned pixel, odd row 2k+1, current column
row_2  input  8  unsigned pixel, even row 2k+2, current column (row bank mirrors row 2k at bottom edge)
iter_var  input  1  0 = first row pair of image (top boundary); 1 = subsequent row pair
row_bank_en  input  1  row bank busy/reloading; high = no column presented this cycle
s  output  8  low-pass coefficient, unsigned
d  output  8  high-pass coefficient, offset-binary (128 = zero)
result  output  1  high for exactly one cycle per column while s/d hold that column's coefficients

Behaviour:
- Reset (resetn=0 at a clk edge): FSM to IDLE; column counter=0; s=0, d=0, result=0; pipeline valid bits cleared. The d bank is not cleared.
- FSM IDLE:
  - en=1 moves the FSM to RUN and latches iter_var for the whole pass.
  - If row_bank_en=0 in that same cycle, the rows present are accepted as column 0.
- FSM RUN:
  - Each cycle with row_bank_en=0 accepts one column and increments the counter.
  - Cycles with row_bank_en=1 accept nothing: counter frozen, bubble inserted.
  - en is ignored in RUN.
  - After column LENGTH-1 is accepted, the FSM returns to IDLE. The pipeline drains on its own.
- Arithmetic, full precision:
  - dd = row_1 - floor((row_0+row_2)/2), 9-bit signed, range -255..255.
  - dp = d_bank[col] if latched iter_var=1, else dd (top-boundary symmetric extension).
  - ss = row_0 + floor((dp+dd+2)/4), using arithmetic shift.
  - s = clamp(ss, 0, 255).
  - d = clamp(dd+128, 0, 255).
  - d_bank[col] <= dd (9-bit) on every accepted column, regardless of iter_var.
- Latency: 2 edges.
  - Stage 1 registers row_0, dd, dp, and valid at the accepting edge E.
  - Stage 2 registers s, d, result at E+1. Outputs are visible after E+1.
- result=0 on bubble cycles and when idle. s and d hold their last values when result=0.
- Back-to-back passes: en in the cycle immediately after the FSM returns to IDLE is legal. The pipeline continues without gaps.
- Reset mid-pass: the pass is aborted; result is 0 from the next edge; no further outputs from that pass.

Test Plan:
- Reset, then en=1 with iter_var=0, row_bank_en=0, column 0 = (10,20,30) -> two edges later result=1, s=10, d=128.
- Pass with iter_var=0, columns (100,200,50), (0,255,0), (255,0,255) -> successive outputs s/d = 163/253, 128/255, 128/0, one per cycle with result continuously high.
- Pass 1 with iter_var=0, column 0=(100,200,50). Then pass 2 with iter_var=1, column 0=(50,60,70) -> pass 2 output s=81, d=128, using the banked dd=125.
- Full LENGTH=256 pass of image data, row_bank_en held 0 -> result high for exactly 256 consecutive cycles, then 0. A second en after completion restarts the count at column 0.
- Assert row_bank_en=1 for 3 cycles mid-pass -> result drops for exactly 3 cycles, column order is preserved, and 256 results are still produced in total.
- Assert resetn=0 for one cycle mid-pass -> result=0, s=0, d=0 from the next edge. en is required to restart.

Source files
------------

// File: rtl/col_processor.sv
// -----------------------------------------------------------------------------
// col_processor
//
// Column-direction stage of the 2-D 5/3 wavelet transformer. For each column
// it takes three vertically adjacent pixels (even row 2k, odd row 2k+1, even
// row 2k+2) and produces one low-pass (s) and one high-pass (d) coefficient
// using one integer lifting step. A start pulse processes LENGTH columns, one
// per cycle, with bubbles whenever the row bank is busy.
//
// Ports:
//   clk          clock, all logic on rising edge
//   resetn       synchronous active-low reset
//   en           start pulse for a pass of LENGTH columns (ignored while running)
//   row_0        pixel of even row 2k, current column (unsigned)
//   row_1        pixel of odd row 2k+1, current column (unsigned)
//   row_2        pixel of even row 2k+2, current column (bottom edge pre-mirrored)
//   iter_var     0 = first row pair (top boundary), 1 = later row pair
//   row_bank_en  high = no column presented this cycle
//   s            low-pass coefficient, unsigned, saturated to 0..255
//   d            high-pass coefficient, offset-binary (128 = zero), saturated
//   result       one-cycle strobe per column while s/d hold its coefficients
// -----------------------------------------------------------------------------
module col_processor #(
  parameter int unsigned LENGTH = 256
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [7:0] row_0,
  input  logic [7:0] row_1,
  input  logic [7:0] row_2,
  input  logic       iter_var,
  input  logic       row_bank_en,
  output logic [7:0] s,
  output logic [7:0] d,
  output logic       result
);

  localparam int unsigned CntW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CntW-1:0] LastCol = CntW'(LENGTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // ---------------------------------------------------------------------------
  // Control: pass FSM and column counter
  // ---------------------------------------------------------------------------
  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_col, w_col_next;
  logic            r_iter, w_iter_next;
  logic            w_iter_eff;
  logic            w_accept;

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_iter_next  = r_iter;
    w_iter_eff   = r_iter;
    w_accept     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (en) begin
          w_state_next = StRun;
          w_iter_next  = iter_var;
          // The start cycle may already carry column 0, so it must see the
          // incoming iter_var rather than the not-yet-latched copy.
          w_iter_eff   = iter_var;
          w_accept     = ~row_bank_en;
        end
      end
      StRun: begin
        w_accept = ~row_bank_en;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (w_accept) begin
      if (r_col == LastCol) begin
        w_col_next   = '0;
        w_state_next = StIdle;
      end else begin
        w_col_next = r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_col   <= '0;
      r_iter  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_iter  <= w_iter_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Predict step: dd = row_1 - floor((row_0 + row_2) / 2)
  // ---------------------------------------------------------------------------
  logic [8:0]        w_pair_sum;
  logic [7:0]        w_pair_avg;
  logic signed [8:0] w_dd;
  logic signed [8:0] w_dp;

  assign w_pair_sum = {1'b0, row_0} + {1'b0, row_2};
  assign w_pair_avg = 8'(w_pair_sum >> 1);
  // True result lies in -255..255, so 9-bit wraparound arithmetic is exact.
  assign w_dd       = $signed({1'b0, row_1} - {1'b0, w_pair_avg});

  // Previous row pair's d per column. Not reset: a new image always starts
  // with iter_var=0, which never reads the bank.
  logic signed [8:0] r_d_bank [LENGTH];

  always_ff @(posedge clk) begin
    if (resetn && w_accept) begin
      r_d_bank[r_col] <= w_dd;
    end
  end

  // Top boundary uses symmetric extension: the missing d above equals dd.
  assign w_dp = w_iter_eff ? r_d_bank[r_col] : w_dd;

  // ---------------------------------------------------------------------------
  // Stage 1 register
  // ---------------------------------------------------------------------------
  logic [7:0]        r_row0;
  logic signed [8:0] r_dd;
  logic signed [8:0] r_dp;
  logic              r_v1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_v1   <= 1'b0;
      r_row0 <= '0;
      r_dd   <= '0;
      r_dp   <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_row0 <= row_0;
        r_dd   <= w_dd;
        r_dp   <= w_dp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Update step: ss = row_0 + floor((dp + dd + 2) / 4), then saturate
  // ---------------------------------------------------------------------------
  logic signed [10:0] w_lift_sum;
  logic signed [10:0] w_update;
  logic signed [10:0] w_ss;
  logic signed [10:0] w_d_ofs;
  logic [7:0]         w_s_sat;
  logic [7:0]         w_d_sat;

  function automatic logic [7:0] sat_u8(input logic signed [10:0] v);
    if (v < 0) begin
      return 8'h00;
    end else if (v > 11'sd255) begin
      return 8'hFF;
    end
    return v[7:0];
  endfunction

  assign w_lift_sum = $signed({{2{r_dp[8]}}, r_dp} + {{2{r_dd[8]}}, r_dd} + 11'd2);
  // Arithmetic shift gives floor division for negative sums.
  assign w_update   = w_lift_sum >>> 2;
  assign w_ss       = $signed({3'b000, r_row0}) + w_update;
  assign w_d_ofs    = $signed({{2{r_dd[8]}}, r_dd}) + 11'sd128;
  assign w_s_sat    = sat_u8(w_ss);
  assign w_d_sat    = sat_u8(w_d_ofs);

  // ---------------------------------------------------------------------------
  // Stage 2 / output register; s and d hold between results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s      <= '0;
      d      <= '0;
      result <= 1'b0;
    end else begin
      result <= r_v1;
      if (r_v1) begin
        s <= w_s_sat;
        d <= w_d_sat;
      end
    end
  end

endmodule

// File: tb/tb_col_processor.sv
// -----------------------------------------------------------------------------
// tb_col_processor
//
// Self-checking bench for col_processor. A behavioural model computes the
// expected s/d/result from the lifting equations with plain integer maths and
// is compared against the DUT every cycle; directed literal checks pin the
// model and the timing of specific scenarios.
// -----------------------------------------------------------------------------
module tb_col_processor;

  localparam int unsigned LENGTH = 256;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic [7:0] row_0 = '0;
  logic [7:0] row_1 = '0;
  logic [7:0] row_2 = '0;
  logic       iter_var = 1'b0;
  logic       row_bank_en = 1'b1;
  logic [7:0] s;
  logic [7:0] d;
  logic       result;

  always #5 clk = ~clk;

  col_processor #(
    .LENGTH(LENGTH)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .row_0      (row_0),
    .row_1      (row_1),
    .row_2      (row_2),
    .iter_var   (iter_var),
    .row_bank_en(row_bank_en),
    .s          (s),
    .d          (d),
    .result     (result)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n++;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_bank [LENGTH];
  bit m_busy = 1'b0;
  int m_col = 0;
  bit m_iter = 1'b0;
  bit m_v1 = 1'b0;
  int m_s1 = 0;
  int m_d1 = 0;
  int m_dd = 0;
  int m_dp = 0;
  bit exp_res = 1'b0;
  int exp_s = 0;
  int exp_d = 0;
  bit chk_on = 1'b0;

  function automatic int clamp8(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic int floor4(input int x);
    if (x >= 0) return x / 4;
    return -((-x + 3) / 4);
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy  = 1'b0;
      m_col   = 0;
      m_v1    = 1'b0;
      exp_res = 1'b0;
      exp_s   = 0;
      exp_d   = 0;
      chk_on  = 1'b1;
    end else begin
      exp_res = m_v1;
      if (m_v1) begin
        exp_s = m_s1;
        exp_d = m_d1;
      end
      if (!m_busy && en) begin
        m_busy = 1'b1;
        m_iter = iter_var;
      end
      m_v1 = 1'b0;
      if (m_busy && !row_bank_en) begin
        m_dd = int'(row_1) - (int'(row_0) + int'(row_2)) / 2;
        m_dp = m_iter ? m_bank[m_col] : m_dd;
        m_s1 = clamp8(int'(row_0) + floor4(m_dp + m_dd + 2));
        m_d1 = clamp8(m_dd + 128);
        m_bank[m_col] = m_dd;
        m_v1 = 1'b1;
        m_col++;
        if (m_col == LENGTH) begin
          m_busy = 1'b0;
          m_col  = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and result capture
  // ---------------------------------------------------------------------------
  int cap_s[$];
  int cap_d[$];
  int cap_t[$];

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (result !== exp_res || s !== 8'(exp_s) || d !== 8'(exp_d)) begin
        miscompares++;
        $display("FAIL cycle %0d: result/s/d = %0b/%0d/%0d, expected %0b/%0d/%0d",
                 edge_n, result, s, d, exp_res, exp_s, exp_d);
      end
    end
    if (result === 1'b1) begin
      cap_s.push_back(int'(s));
      cap_d.push_back(int'(d));
      cap_t.push_back(edge_n);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int p0 [LENGTH];
  int p1 [LENGTH];
  int p2 [LENGTH];
  int t_en = 0;

  task automatic fill(input int seed);
    for (int k = 0; k < LENGTH; k++) begin
      p0[k] = (k * seed + 3) & 255;
      p1[k] = (k * k + seed * 17) & 255;
      p2[k] = (255 - k * (seed + 2)) & 255;
    end
  endtask

  task automatic clear_cap();
    cap_s.delete();
    cap_d.delete();
    cap_t.delete();
  endtask

  // One pass; bub_at/abort_at < 0 disables the bubble/abort.
  task automatic do_pass(input bit it, input int bub_at, input int bub_len, input int abort_at);
    int  k;
    int  nb;
    bit  first;
    k = 0;
    nb = 0;
    first = 1'b1;
    while (k < LENGTH) begin
      if (k == abort_at) begin
        en = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      // A second en mid-pass must be ignored.
      en = first || (k == 5);
      if (first) t_en = edge_n;
      first = 1'b0;
      iter_var = it;
      if (k == bub_at && nb < bub_len) begin
        row_bank_en = 1'b1;
        row_0 = 8'hA5;
        row_1 = 8'h5A;
        row_2 = 8'h3C;
        nb++;
      end else begin
        row_bank_en = 1'b0;
        row_0 = 8'(p0[k]);
        row_1 = 8'(p1[k]);
        row_2 = 8'(p2[k]);
        k++;
      end
      @(negedge clk);
    end
    en = 1'b0;
    row_bank_en = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset result", result, 0);
    check("reset s", s, 0);
    check("reset d", d, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Column 0 = (10,20,30), top boundary: s=10, d=128 two edges after start.
    fill(7);
    p0[0] = 10; p1[0] = 20; p2[0] = 30;
    clear_cap();
    do_pass(1'b0, -1, 0, -1);
    repeat (3) @(negedge clk);
    check("t1 count", cap_s.size(), LENGTH);
    if (cap_s.size() == LENGTH) begin
      check("t1 latency", cap_t[0] - t_en, 2);
      check("t1 s0", cap_s[0], 10);
      check("t1 d0", cap_d[0], 128);
      check("t1 contiguous", cap_t[LENGTH-1] - cap_t[0], LENGTH - 1);
    end

    // Saturation cases, one output per cycle.
    fill(13);
    p0[0] = 100; p1[0] = 200; p2[0] = 50;
    p0[1] = 0;   p1[1] = 255; p2[1] = 0;
    p0[2] = 255; p1[2] = 0;   p2[2] = 255;
    clear_cap();
    do_pass(1'b0, -1, 0, -1);
    repeat (3) @(negedge clk);
    check("t2 count", cap_s.size(), LENGTH);
    if (cap_s.size() == LENGTH) begin
      check("t2 s0", cap_s[0], 163);
      check("t2 d0", cap_d[0], 253);
      check("t2 s1", cap_s[1], 128);
      check("t2 d1", cap_d[1], 255);
      check("t2 s2", cap_s[2], 128);
      check("t2 d2", cap_d[2], 0);
      check("t2 back-to-back", cap_t[2] - cap_t[0], 2);
    end

    // Subsequent row pair uses banked dd=125 for column 0.
    fill(5);
    p0[0] = 50; p1[0] = 60; p2[0] = 70;
    clear_cap();
    do_pass(1'b1, -1, 0, -1);
    repeat (3) @(negedge clk);
    check("t3 count", cap_s.size(), LENGTH);
    if (cap_s.size() == LENGTH) begin
      check("t3 s0", cap_s[0], 81);
      check("t3 d0", cap_d[0], 128);
    end

    // Three-cycle bubble at column 100, then an immediate second pass.
    fill(3);
    clear_cap();
    do_pass(1'b1, 100, 3, -1);
    fill(9);
    do_pass(1'b0, -1, 0, -1);
    repeat (3) @(negedge clk);
    check("t4 count", cap_s.size(), 2 * LENGTH);
    if (cap_s.size() == 2 * LENGTH) begin
      check("t4 bubble gap", cap_t[100] - cap_t[99], 4);
      check("t4 pass1 span", cap_t[LENGTH-1] - cap_t[0], LENGTH - 1 + 3);
      check("t4 seam", cap_t[LENGTH] - cap_t[LENGTH-1], 1);
      check("t4 pass2 span", cap_t[2*LENGTH-1] - cap_t[LENGTH], LENGTH - 1);
    end

    // Reset after 50 columns: outputs cleared, nothing more from that pass.
    fill(11);
    clear_cap();
    do_pass(1'b0, -1, 0, 50);
    check("t5 result after reset", result, 0);
    check("t5 s after reset", s, 0);
    check("t5 d after reset", d, 0);
    repeat (5) @(negedge clk);
    check("t5 aborted count", cap_s.size(), 49);
    clear_cap();
    do_pass(1'b0, -1, 0, -1);
    repeat (3) @(negedge clk);
    check("t5 restart count", cap_s.size(), LENGTH);
    if (cap_s.size() == LENGTH) begin
      check("t5 restart latency", cap_t[0] - t_en, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
